// File: rtl/evu_counter.sv
// Event counter behind the event mux: selects an event line, samples it and
// accumulates pulses into a wide counter with threshold/overflow status and irq.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// DISABLED | en=0, counter holds
// SETTLE   | waiting for mux output and event_q to reflect the new select
// COUNTING | pulses increment the counter (frozen while debug_mode_i=1)
// HALTED   | threshold reached with stop_on_thr, counter holds
module evu_counter #(
    parameter int CNT_WIDTH = 64,
    parameter int SEL_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 evu_event_i,
    output logic [SEL_WIDTH-1:0] sel_line_o,
    input  logic                 debug_mode_i,
    input  logic [1:0]           csr_addr_i,
    input  logic                 csr_we_i,
    input  logic                 csr_re_i,
    input  logic [CNT_WIDTH-1:0] csr_wdata_i,
    output logic [CNT_WIDTH-1:0] csr_rdata_o,
    output logic                 csr_rvalid_o,
    output logic                 irq_o
);

    localparam int CTRL_W = 4 + SEL_WIDTH;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_COUNT  = 2'd1;
    localparam logic [1:0] ADDR_THRESH = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] SETTLE_LOAD = 2'd2;
    localparam logic [1:0] SETTLE_TC   = 2'd1;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        SETTLE   = 2'd1,
        COUNTING = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [1:0] settle_q, settle_d;

    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] thresh_q, thresh_d;
    logic [1:0]           status_q, status_d;
    logic                 event_q;

    logic wr_ctrl, wr_count, wr_thresh, wr_status;
    logic en_d, edge_mode, irq_en, stop_on_thr;
    logic [SEL_WIDTH-1:0] sel_q;
    logic sel_change, pulse, inc_fire, thr_set, ovf_set, thr_clr;
    logic [CNT_WIDTH-1:0] count_inc;
    logic [1:0] status_clr;
    logic [CNT_WIDTH-1:0] rd_mux;

    assign wr_ctrl   = csr_we_i && (csr_addr_i == ADDR_CTRL);
    assign wr_count  = csr_we_i && (csr_addr_i == ADDR_COUNT);
    assign wr_thresh = csr_we_i && (csr_addr_i == ADDR_THRESH);
    assign wr_status = csr_we_i && (csr_addr_i == ADDR_STATUS);

    assign ctrl_d      = wr_ctrl ? csr_wdata_i[CTRL_W-1:0] : ctrl_q;
    assign en_d        = ctrl_d[0];
    assign edge_mode   = ctrl_q[1];
    assign irq_en      = ctrl_q[2];
    assign stop_on_thr = ctrl_q[3];
    assign sel_q       = ctrl_q[4 +: SEL_WIDTH];
    assign sel_change  = wr_ctrl && (csr_wdata_i[4 +: SEL_WIDTH] != sel_q);

    assign pulse = edge_mode ? (evu_event_i & ~event_q) : evu_event_i;

    // A COUNT write owns the cycle: the discarded increment must not flag status.
    assign inc_fire  = (state_q == COUNTING) && pulse && !debug_mode_i && !wr_count;
    assign count_inc = count_q + CNT_WIDTH'(1);
    assign thr_set   = inc_fire && (thresh_q != '0) && (count_inc == thresh_q);
    assign ovf_set   = inc_fire && (count_inc == '0);

    assign count_d  = wr_count ? csr_wdata_i : (inc_fire ? count_inc : count_q);
    assign thresh_d = wr_thresh ? csr_wdata_i : thresh_q;

    // New sets are OR-ed in after the clear so a coincident set wins.
    assign status_clr = wr_status ? csr_wdata_i[1:0] : 2'b00;
    assign status_d   = (status_q & ~status_clr) | {ovf_set, thr_set};
    assign thr_clr    = wr_status && csr_wdata_i[0] && status_q[0];

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            DISABLED: begin
                if (en_d) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (!en_d) begin
                    state_d = DISABLED;
                end else if (sel_change) begin
                    settle_d = SETTLE_LOAD;
                end else if (settle_q == SETTLE_TC) begin
                    state_d = COUNTING;
                end else begin
                    settle_d = settle_q - 2'd1;
                end
            end
            COUNTING: begin
                if (!en_d) begin
                    state_d = DISABLED;
                end else if (sel_change) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                end else if (thr_set && stop_on_thr) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!en_d) begin
                    state_d = DISABLED;
                end else if (thr_clr) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end
            default: state_d = DISABLED;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (csr_addr_i)
            ADDR_CTRL:   rd_mux = CNT_WIDTH'(ctrl_q);
            ADDR_COUNT:  rd_mux = count_q;
            ADDR_THRESH: rd_mux = thresh_q;
            ADDR_STATUS: rd_mux = CNT_WIDTH'(status_q);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= DISABLED;
            settle_q     <= 2'd0;
            ctrl_q       <= '0;
            count_q      <= '0;
            thresh_q     <= '0;
            status_q     <= 2'b00;
            event_q      <= 1'b0;
            sel_line_o   <= '0;
            csr_rdata_o  <= '0;
            csr_rvalid_o <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            ctrl_q       <= ctrl_d;
            count_q      <= count_d;
            thresh_q     <= thresh_d;
            status_q     <= status_d;
            event_q      <= evu_event_i;
            sel_line_o   <= sel_q;
            csr_rvalid_o <= csr_re_i;
            irq_o        <= irq_en & (|status_q);
            if (csr_re_i) begin
                csr_rdata_o <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_evu_counter.sv
// Directed bench for evu_counter: settle, edge/level counting, wrap, threshold
// halt, debug freeze, CSR priorities and mid-operation reset.
module tb_evu_counter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        evu_event_i;
    logic [3:0]  sel_line_o;
    logic        debug_mode_i;
    logic [1:0]  csr_addr_i;
    logic        csr_we_i;
    logic        csr_re_i;
    logic [63:0] csr_wdata_i;
    logic [63:0] csr_rdata_o;
    logic        csr_rvalid_o;
    logic        irq_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    evu_counter #(.CNT_WIDTH(64), .SEL_WIDTH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .evu_event_i  (evu_event_i),
        .sel_line_o   (sel_line_o),
        .debug_mode_i (debug_mode_i),
        .csr_addr_i   (csr_addr_i),
        .csr_we_i     (csr_we_i),
        .csr_re_i     (csr_re_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_rvalid_o (csr_rvalid_o),
        .irq_o        (irq_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] addr, input logic [63:0] data);
        csr_addr_i  = addr;
        csr_wdata_i = data;
        csr_we_i    = 1'b1;
        tick();
        csr_we_i    = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] addr, input logic [63:0] exp);
        csr_addr_i = addr;
        csr_re_i   = 1'b1;
        tick();
        csr_re_i   = 1'b0;
        check_val({tag, "_rvalid"}, {63'd0, csr_rvalid_o}, 64'd1);
        check_val(tag, csr_rdata_o, exp);
    endtask

    task automatic events(input int n, input logic val);
        evu_event_i = val;
        for (int i = 0; i < n; i++) tick();
        evu_event_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        evu_event_i  = 1'b0;
        debug_mode_i = 1'b0;
        csr_addr_i   = 2'd0;
        csr_we_i     = 1'b0;
        csr_re_i     = 1'b0;
        csr_wdata_i  = '0;
        tick(); tick(); tick();
        rst_i = 1'b0;
        tick();
        check_val("rst_sel", {60'd0, sel_line_o}, 64'd0);
        check_val("rst_rdata", csr_rdata_o, 64'd0);
        check_val("rst_rvalid", {63'd0, csr_rvalid_o}, 64'd0);
        check_val("rst_irq", {63'd0, irq_o}, 64'd0);
        read_check("rst_count", 2'd1, 64'd0);
        tick();
        check_val("rvalid_pulse", {63'd0, csr_rvalid_o}, 64'd0);

        // level mode, sel=2: 10 event cycles, first 2 dropped by settle
        csr_write(2'd0, 64'h21);
        check_val("sel_before", {60'd0, sel_line_o}, 64'd0);
        evu_event_i = 1'b1;
        tick();
        check_val("sel_after", {60'd0, sel_line_o}, 64'd2);
        for (int i = 1; i < 10; i++) tick();
        evu_event_i = 1'b0;
        read_check("level_count", 2'd1, 64'd8);
        read_check("ctrl_rd", 2'd0, 64'h21);

        // edge mode after a fresh settle
        csr_write(2'd0, 64'h0);
        csr_write(2'd1, 64'h0);
        csr_write(2'd0, 64'h23);
        tick(); tick();
        begin
            logic [6:0] pat;
            pat = 7'b1001011;
            for (int i = 0; i < 7; i++) begin
                evu_event_i = pat[i];
                tick();
            end
            evu_event_i = 1'b0;
        end
        read_check("edge_count", 2'd1, 64'd3);

        // wrap: ovf set, thresh=0 never hits, irq one cycle later
        csr_write(2'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        csr_write(2'd0, 64'h25);
        evu_event_i = 1'b1;
        tick(); tick();
        evu_event_i = 1'b0;
        check_val("ovf_irq_early", {63'd0, irq_o}, 64'd0);
        tick();
        check_val("ovf_irq", {63'd0, irq_o}, 64'd1);
        read_check("wrap_count", 2'd1, 64'd0);
        read_check("ovf_status", 2'd3, 64'd2);
        csr_write(2'd3, 64'h2);
        tick();
        check_val("ovf_irq_clr", {63'd0, irq_o}, 64'd0);

        // threshold with stop: halts at 5, resumes after W1C and settle
        csr_write(2'd2, 64'd5);
        csr_write(2'd1, 64'd0);
        csr_write(2'd0, 64'h2D);
        events(8, 1'b1);
        check_val("thr_irq", {63'd0, irq_o}, 64'd1);
        read_check("halt_count", 2'd1, 64'd5);
        read_check("thr_status", 2'd3, 64'd1);
        csr_write(2'd3, 64'h1);
        events(4, 1'b1);
        read_check("resume_count", 2'd1, 64'd7);
        read_check("resume_status", 2'd3, 64'd0);

        // debug freeze for 4 of 10 event cycles
        csr_write(2'd0, 64'h21);
        csr_write(2'd2, 64'd0);
        csr_write(2'd1, 64'd0);
        evu_event_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            debug_mode_i = (i >= 3 && i < 7);
            tick();
        end
        debug_mode_i = 1'b0;
        evu_event_i  = 1'b0;
        read_check("debug_count", 2'd1, 64'd6);

        // COUNT write beats a coincident increment
        evu_event_i = 1'b1;
        csr_write(2'd1, 64'h1234);
        evu_event_i = 1'b0;
        read_check("wr_wins", 2'd1, 64'h1234);

        // back-to-back reads, first coincides with an increment
        evu_event_i = 1'b1;
        csr_addr_i  = 2'd1;
        csr_re_i    = 1'b1;
        tick();
        evu_event_i = 1'b0;
        check_val("rd_pre_inc", csr_rdata_o, 64'h1234);
        check_val("rd_pre_vld", {63'd0, csr_rvalid_o}, 64'd1);
        tick();
        csr_re_i = 1'b0;
        check_val("rd_b2b", csr_rdata_o, 64'h1235);
        check_val("rd_b2b_vld", {63'd0, csr_rvalid_o}, 64'd1);

        // W1C and a new thr_hit in the same cycle: set wins
        csr_write(2'd2, 64'h1236);
        evu_event_i = 1'b1;
        csr_write(2'd3, 64'h1);
        evu_event_i = 1'b0;
        read_check("set_wins", 2'd3, 64'd1);
        read_check("set_count", 2'd1, 64'h1236);

        // write and read same address in one cycle returns old value
        csr_addr_i  = 2'd1;
        csr_wdata_i = 64'h55;
        csr_we_i    = 1'b1;
        csr_re_i    = 1'b1;
        tick();
        csr_we_i = 1'b0;
        csr_re_i = 1'b0;
        check_val("rw_old", csr_rdata_o, 64'h1236);
        read_check("rw_new", 2'd1, 64'h55);

        // reset mid-count with a read pending
        evu_event_i = 1'b1;
        tick(); tick();
        csr_addr_i = 2'd1;
        csr_re_i   = 1'b1;
        rst_i      = 1'b1;
        tick();
        csr_re_i = 1'b0;
        rst_i    = 1'b0;
        check_val("mid_rst_rvalid", {63'd0, csr_rvalid_o}, 64'd0);
        check_val("mid_rst_rdata", csr_rdata_o, 64'd0);
        check_val("mid_rst_irq", {63'd0, irq_o}, 64'd0);
        check_val("mid_rst_sel", {60'd0, sel_line_o}, 64'd0);
        events(5, 1'b1);
        read_check("mid_rst_ctrl", 2'd0, 64'd0);
        read_check("mid_rst_count", 2'd1, 64'd0);
        read_check("mid_rst_status", 2'd3, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
